// File: rtl/sys_spm_req_arbiter.sv
// ---------------------------------------------------------------------------
// sys_spm_req_arbiter
//
// Purpose:
//   Shares the single system-scratchpad (SPM) request channel between NumReq
//   requesters using round-robin arbitration. The grant is held stable while
//   the memory back-pressures. Every accepted request records its requester
//   index in an in-order outstanding FIFO. Each memory response is steered
//   back to the requester that issued it.
//
// Handshake semantics (valid/ready on both sides):
//   A transfer happens in a cycle where the source asserts valid and the sink
//   asserts ready/gnt. Once a source has asserted valid, it holds valid and
//   payload stable until the transfer happens. On the requester side, the
//   request is req_valid_i[i] and the accept is req_ready_o[i]. On the memory
//   side, the request is mem_req_o and the accept is mem_gnt_i. The response
//   path (mem_rvalid_i -> rsp_valid_o) has no back-pressure.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_valid_i         per-requester request valid
//   req_ready_o         per-requester accept (pulses on the handshake cycle)
//   req_addr_i          per-requester request payload: address
//   req_we_i            per-requester request payload: write enable
//   req_wdata_i         per-requester request payload: write data
//   req_be_i            per-requester request payload: byte enables
//   rsp_valid_o         one-hot response strobe
//   rsp_rdata_o         response data, shared by all requesters
//   mem_req_o           memory request valid
//   mem_gnt_i           memory accept
//   mem_addr_o          payload of the granted requester: address
//   mem_we_o            payload of the granted requester: write enable
//   mem_wdata_o         payload of the granted requester: write data
//   mem_be_o            payload of the granted requester: byte enables
//   mem_rvalid_i        memory response, in request order
//   mem_rdata_i         memory response data
//   err_o               sticky: response seen with nothing outstanding
//   perf_stall_cnt_o    per-requester stall counters
//
// Configuration macro:
//   SYS_SPM_ARB_PERF_CNT_EN - when defined, builds saturating 16-bit stall
//   counters. When undefined, perf_stall_cnt_o is tied to zero.
// ---------------------------------------------------------------------------
module sys_spm_req_arbiter #(
  parameter int NumReq         = 4,
  parameter int AddrWidth      = 20,
  parameter int DataWidth      = 64,
  parameter int MaxOutstanding = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
  input  logic [NumReq-1:0]                   req_we_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    req_wdata_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]  req_be_i,
  output logic [NumReq-1:0]                   rsp_valid_o,
  output logic [DataWidth-1:0]                rsp_rdata_o,
  output logic                                mem_req_o,
  input  logic                                mem_gnt_i,
  output logic [AddrWidth-1:0]                mem_addr_o,
  output logic                                mem_we_o,
  output logic [DataWidth-1:0]                mem_wdata_o,
  output logic [DataWidth/8-1:0]              mem_be_o,
  input  logic                                mem_rvalid_i,
  input  logic [DataWidth-1:0]                mem_rdata_i,
  output logic                                err_o,
  output logic [NumReq-1:0][15:0]             perf_stall_cnt_o
);

  localparam int IdxW = $clog2(NumReq);
  localparam int PtrW = $clog2(MaxOutstanding);
  localparam int CntW = PtrW + 1;
  localparam int BeW  = DataWidth / 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [IdxW-1:0]     lock_idx_q, lock_idx_d;
  logic [IdxW-1:0]     last_q, last_d;

  logic [IdxW-1:0]     fifo_q [MaxOutstanding];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                err_q, err_d;

  // -------------------------------------------------------------------------
  // Round-robin pick: first valid requester strictly after last_q, wrapping.
  // -------------------------------------------------------------------------
  logic                rr_found;
  logic [IdxW-1:0]     rr_idx;
  logic [IdxW-1:0]     cand;

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last_q;
    cand     = '0;
    for (int k = 1; k <= NumReq; k++) begin
      cand = IdxW'((int'(last_q) + k) % NumReq);
      if (!rr_found && req_valid_i[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Grant selection and memory request
  // -------------------------------------------------------------------------
  logic                grant_valid;
  logic [IdxW-1:0]     grant_idx;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  // The full check uses the registered count only. A pop in the same cycle
  // frees a slot for the next cycle, not this one. This keeps mem_req_o
  // independent of mem_rvalid_i.
  assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
  assign fifo_empty = (cnt_q == '0);

  always_comb begin
    if (state_q == LOCKED) begin
      // The locked requester keeps the grant regardless of other valids.
      grant_idx   = lock_idx_q;
      grant_valid = req_valid_i[lock_idx_q];
    end else begin
      grant_idx   = rr_idx;
      grant_valid = rr_found;
    end
  end

  assign mem_req_o = grant_valid && !fifo_full;
  assign push      = mem_req_o && mem_gnt_i;
  assign pop       = mem_rvalid_i && !fifo_empty;

  // Payload is the granted requester's payload, driven to zero when no
  // request is presented.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (mem_req_o) begin
      mem_addr_o  = req_addr_i[grant_idx];
      mem_we_o    = req_we_i[grant_idx];
      mem_wdata_o = req_wdata_i[grant_idx];
      mem_be_o    = req_be_i[grant_idx];
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (push) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Arbitration FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    last_d     = last_q;
    if (push) begin
      state_d = IDLE;
      last_d  = grant_idx;
    end else if (mem_req_o) begin
      // The memory is back-pressuring, so freeze this grant until accepted.
      state_d    = LOCKED;
      lock_idx_d = grant_idx;
    end else if (!grant_valid) begin
      // Nothing to present. If a locked requester withdrew its valid, which
      // is a protocol violation, fall back to arbitration rather than hang.
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
      last_q     <= IdxW'(NumReq - 1);
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      last_q     <= last_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outstanding FIFO (requester index of every accepted request)
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // A response with nothing outstanding is dropped and flagged until reset.
  // This includes responses to requests that were accepted before a reset.
  assign err_d = err_q || (mem_rvalid_i && fifo_empty);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MaxOutstanding; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= grant_idx;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign err_o = err_q;

  // -------------------------------------------------------------------------
  // Response routing: combinational strobe to the FIFO head's requester.
  // -------------------------------------------------------------------------
  always_comb begin
    rsp_valid_o = '0;
    if (pop) begin
      rsp_valid_o[fifo_q[rd_ptr_q]] = 1'b1;
    end
  end

  assign rsp_rdata_o = mem_rdata_i;

  // -------------------------------------------------------------------------
  // Stall counters
  // -------------------------------------------------------------------------
`ifdef SYS_SPM_ARB_PERF_CNT_EN
  logic [NumReq-1:0][15:0] perf_q;

  // Count every cycle a requester waits: valid high but not accepted.
  // Each counter saturates at 16'hFFFF.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (req_valid_i[i] && !req_ready_o[i] && (perf_q[i] != 16'hFFFF)) begin
          perf_q[i] <= perf_q[i] + 16'd1;
        end
      end
    end
  end

  assign perf_stall_cnt_o = perf_q;
`else
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sys_spm_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sys_spm_req_arbiter
//
// Purpose:
//   Self-checking bench for sys_spm_req_arbiter with default parameters.
//   A behavioural model tracks the outstanding requesters in an expected
//   queue, together with the last grant, the current lock, the sticky error
//   and the stall counts. Inputs are driven 1 ns after the rising edge.
//   Outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_sys_spm_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 20;
  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam int MO = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic [N-1:0]         req_valid_i, req_ready_o, req_we_i, rsp_valid_o;
  logic [N-1:0][AW-1:0] req_addr_i;
  logic [N-1:0][DW-1:0] req_wdata_i;
  logic [N-1:0][BW-1:0] req_be_i;
  logic [DW-1:0]        rsp_rdata_o, mem_wdata_o, mem_rdata_i;
  logic                 mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, err_o;
  logic [AW-1:0]        mem_addr_o;
  logic [BW-1:0]        mem_be_o;
  logic [N-1:0][15:0]   perf_stall_cnt_o;

  sys_spm_req_arbiter #(
    .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i),
    .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o), .perf_stall_cnt_o(perf_stall_cnt_o)
  );

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  // ---------------------------------------------------------------------------
  // Reference model / scoreboard
  // ---------------------------------------------------------------------------
  logic [1:0]   exp_q[$];   // requester index of each outstanding request
  int           last_g;
  int           lock_g;     // -1 when no grant is frozen
  bit           m_err;
  int           m_perf[N];
  int           exp_g;
  logic         exp_req;
  logic [N-1:0] exp_ready, exp_rsp;

  function automatic void model_reset();
    last_g = N - 1;
    lock_g = -1;
    exp_q.delete();
    m_err = 1'b0;
    for (int i = 0; i < N; i++) m_perf[i] = 0;
  endfunction

  function automatic void model_eval();
    exp_g = -1;
    if (lock_g >= 0) begin
      exp_g = lock_g;
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (exp_g < 0 && req_valid_i[(last_g + k) % N]) exp_g = (last_g + k) % N;
      end
    end
    exp_req   = (exp_g >= 0) && req_valid_i[exp_g] && (exp_q.size() < MO);
    exp_ready = (exp_req && mem_gnt_i) ? N'(1) << exp_g : '0;
    exp_rsp   = (mem_rvalid_i && exp_q.size() > 0) ? N'(1) << exp_q[0] : '0;
  endfunction

  function automatic void model_commit();
    if (mem_rvalid_i && exp_q.size() == 0) m_err = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (req_valid_i[i] && !exp_ready[i] && m_perf[i] < 65535) m_perf[i]++;
    end
    if (mem_rvalid_i && exp_q.size() > 0) void'(exp_q.pop_front());
    if (exp_req && mem_gnt_i) begin
      exp_q.push_back(2'(exp_g));
      last_g = exp_g;
      lock_g = -1;
    end else if (exp_req) begin
      lock_g = exp_g;
    end else begin
      lock_g = -1;
    end
  endfunction

  function automatic int exp_perf(int i);
`ifdef SYS_SPM_ARB_PERF_CNT_EN
    return m_perf[i];
`else
    return 0;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic settle();
    @(negedge clk_i);
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rand_payload(int i);
    req_addr_i[i]  = AW'($urandom_range(0, (1 << AW) - 1));
    req_we_i[i]    = 1'($urandom_range(0, 1));
    req_wdata_i[i] = {$urandom, $urandom};
    req_be_i[i]    = BW'($urandom_range(0, 255));
  endtask

  task automatic do_reset();
    req_valid_i  = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    rst_i        = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    settle();
    cmp_cnt++;
    if ({mem_req_o, req_ready_o, rsp_valid_o, err_o} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_ctrl got req=%b rdy=%b rsp=%b err=%b exp all 0",
               mem_req_o, req_ready_o, rsp_valid_o, err_o);
    end
    cmp_cnt++;
    if ({mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_payload got addr=%h we=%b be=%h exp 0", mem_addr_o, mem_we_o, mem_be_o);
    end
    cmp_cnt++;
    if (perf_stall_cnt_o !== '0) begin
      fail_cnt++;
      $display("FAIL reset_perf got %h exp 0", perf_stall_cnt_o);
    end
    advance();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) rand_payload(i);
    req_valid_i = '1;
    mem_gnt_i   = 1'b1;
    for (int c = 0; c < 12; c++) begin
      mem_rvalid_i = (c > 0);
      mem_rdata_i  = {$urandom, $urandom};
      settle();
      cmp_cnt++;
      if (req_ready_o !== (N'(1) << (c % N))) begin
        fail_cnt++;
        $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, req_ready_o, N'(1) << (c % N));
      end
      cmp_cnt++;
      if (mem_addr_o !== req_addr_i[c % N]) begin
        fail_cnt++;
        $display("FAIL rr_addr cyc=%0d got=%h exp=%h", c, mem_addr_o, req_addr_i[c % N]);
      end
      cmp_cnt++;
      if (rsp_valid_o !== ((c > 0) ? N'(1) << ((c - 1) % N) : N'(0))) begin
        fail_cnt++;
        $display("FAIL rr_rsp cyc=%0d got=%b exp=%b", c, rsp_valid_o,
                 (c > 0) ? N'(1) << ((c - 1) % N) : N'(0));
      end
      cmp_cnt++;
      if (rsp_rdata_o !== mem_rdata_i) begin
        fail_cnt++;
        $display("FAIL rr_rdata cyc=%0d got=%h exp=%h", c, rsp_rdata_o, mem_rdata_i);
      end
      advance();
    end
    req_valid_i  = '0;
    mem_rvalid_i = 1'b0;
  endtask

  task automatic test_lock();
    logic [AW-1:0] a2;
    do_reset();
    for (int i = 0; i < N; i++) rand_payload(i);
    a2          = req_addr_i[2];
    req_valid_i = 4'b0100;
    mem_gnt_i   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) req_valid_i[0] = 1'b1;
      settle();
      cmp_cnt++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== a2 || req_ready_o !== '0) begin
        fail_cnt++;
        $display("FAIL lock_hold cyc=%0d got req=%b addr=%h rdy=%b exp req=1 addr=%h rdy=0",
                 c, mem_req_o, mem_addr_o, req_ready_o, a2);
      end
      advance();
    end
    mem_gnt_i = 1'b1;
    settle();
    cmp_cnt++;
    if (req_ready_o !== 4'b0100) begin
      fail_cnt++;
      $display("FAIL lock_gnt got=%b exp=0100", req_ready_o);
    end
    advance();
    req_valid_i[2] = 1'b0;
    settle();
    cmp_cnt++;
    if (req_ready_o !== 4'b0001 || mem_addr_o !== req_addr_i[0]) begin
      fail_cnt++;
      $display("FAIL lock_next got rdy=%b addr=%h exp rdy=0001 addr=%h",
               req_ready_o, mem_addr_o, req_addr_i[0]);
    end
    advance();
  endtask

  task automatic test_full();
    int hs;
    do_reset();
    rand_payload(1);
    req_valid_i = 4'b0010;
    mem_gnt_i   = 1'b1;
    hs          = 0;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (req_ready_o[1]) hs++;
      cmp_cnt++;
      if (req_ready_o !== exp_ready) begin
        fail_cnt++;
        $display("FAIL full_ready cyc=%0d got=%b exp=%b", c, req_ready_o, exp_ready);
      end
      advance();
    end
    cmp_cnt++;
    if (hs != MO) begin
      fail_cnt++;
      $display("FAIL full_handshakes got=%0d exp=%0d", hs, MO);
    end
    mem_rvalid_i = 1'b1;
    settle();
    cmp_cnt++;
    if (rsp_valid_o !== 4'b0010 || mem_req_o !== 1'b0) begin
      fail_cnt++;
      $display("FAIL full_pop got rsp=%b req=%b exp rsp=0010 req=0", rsp_valid_o, mem_req_o);
    end
    advance();
    mem_rvalid_i = 1'b0;
    settle();
    cmp_cnt++;
    if (mem_req_o !== 1'b1 || req_ready_o !== 4'b0010) begin
      fail_cnt++;
      $display("FAIL full_regrant got req=%b rdy=%b exp req=1 rdy=0010", mem_req_o, req_ready_o);
    end
    advance();
  endtask

  task automatic test_err();
    do_reset();
    mem_rvalid_i = 1'b1;
    settle();
    cmp_cnt++;
    if (rsp_valid_o !== '0) begin
      fail_cnt++;
      $display("FAIL err_rsp got=%b exp=0", rsp_valid_o);
    end
    advance();
    mem_rvalid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      cmp_cnt++;
      if (err_o !== 1'b1) begin
        fail_cnt++;
        $display("FAIL err_sticky cyc=%0d got=%b exp=1", c, err_o);
      end
      advance();
    end
    do_reset();
    settle();
    cmp_cnt++;
    if (err_o !== 1'b0) begin
      fail_cnt++;
      $display("FAIL err_clear got=%b exp=0", err_o);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < N; i++) rand_payload(i);
    req_valid_i = 4'b0001;
    mem_gnt_i   = 1'b1;
    repeat (2) begin
      settle();
      advance();
    end
    do_reset();
    mem_rvalid_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle();
      cmp_cnt++;
      if (rsp_valid_o !== '0) begin
        fail_cnt++;
        $display("FAIL rstmid_rsp cyc=%0d got=%b exp=0", c, rsp_valid_o);
      end
      advance();
    end
    mem_rvalid_i = 1'b0;
    req_valid_i  = '1;
    mem_gnt_i    = 1'b1;
    settle();
    cmp_cnt++;
    if (err_o !== 1'b1 || req_ready_o !== 4'b0001) begin
      fail_cnt++;
      $display("FAIL rstmid_after got err=%b rdy=%b exp err=1 rdy=0001", err_o, req_ready_o);
    end
    advance();
    req_valid_i = '0;
  endtask

  task automatic test_perf();
    int want;
    do_reset();
    rand_payload(3);
    req_valid_i = 4'b1000;
    mem_gnt_i   = 1'b0;
    repeat (10) begin
      settle();
      advance();
    end
`ifdef SYS_SPM_ARB_PERF_CNT_EN
    want = 10;
`else
    want = 0;
`endif
    mem_gnt_i = 1'b1;
    settle();
    cmp_cnt++;
    if (perf_stall_cnt_o[3] !== 16'(want) || req_ready_o !== 4'b1000) begin
      fail_cnt++;
      $display("FAIL perf_stall got cnt=%0d rdy=%b exp cnt=%0d rdy=1000",
               perf_stall_cnt_o[3], req_ready_o, want);
    end
    advance();
    req_valid_i = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < N; i++) rand_payload(i);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (i != lock_g) begin
          req_valid_i[i] = ($urandom_range(0, 9) < 6);
          if ($urandom_range(0, 1) == 1) rand_payload(i);
        end
      end
      mem_gnt_i    = ($urandom_range(0, 3) != 0);
      mem_rvalid_i = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata_i  = {$urandom, $urandom};
      settle();
      cmp_cnt++;
      if (mem_req_o !== exp_req || req_ready_o !== exp_ready) begin
        fail_cnt++;
        $display("FAIL rnd_req cyc=%0d got req=%b rdy=%b exp req=%b rdy=%b",
                 c, mem_req_o, req_ready_o, exp_req, exp_ready);
      end
      cmp_cnt++;
      if (rsp_valid_o !== exp_rsp || rsp_rdata_o !== mem_rdata_i) begin
        fail_cnt++;
        $display("FAIL rnd_rsp cyc=%0d got=%b exp=%b", c, rsp_valid_o, exp_rsp);
      end
      if (exp_req) begin
        cmp_cnt++;
        if ({mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o} !==
            {req_addr_i[exp_g], req_we_i[exp_g], req_wdata_i[exp_g], req_be_i[exp_g]}) begin
          fail_cnt++;
          $display("FAIL rnd_payload cyc=%0d got addr=%h exp addr=%h (req %0d)",
                   c, mem_addr_o, req_addr_i[exp_g], exp_g);
        end
      end
      cmp_cnt++;
      if (err_o !== m_err) begin
        fail_cnt++;
        $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, err_o, m_err);
      end
      for (int i = 0; i < N; i++) begin
        cmp_cnt++;
        if (perf_stall_cnt_o[i] !== 16'(exp_perf(i))) begin
          fail_cnt++;
          $display("FAIL rnd_perf cyc=%0d req=%0d got=%0d exp=%0d",
                   c, i, perf_stall_cnt_o[i], exp_perf(i));
        end
      end
      advance();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    rst_i        = 1'b1;
    req_valid_i  = '0;
    req_addr_i   = '0;
    req_we_i     = '0;
    req_wdata_i  = '0;
    req_be_i     = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_err();
    test_reset_mid();
    test_perf();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
